// File: rtl/axis_read_sched.sv
// axis_read_sched: splits one stream read into AXI AR bursts (<= BURST_MAX beats, never crossing 4 KB) and tracks completion.
// Define AXIS_READ_SCHED_BURST_CNT_EN to add the burst_cnt output.
module axis_read_sched #(
  parameter int CONFIG_DWIDTH   = 32,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_LEN_WIDTH   = 8,
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int WIDTH_RATIO     = 2,
  parameter int BURST_MAX       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CONFIG_DWIDTH-1:0]  cfg_address,
  input  logic [CONFIG_DWIDTH-1:0]  cfg_length,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  output logic [CONFIG_DWIDTH-1:0]  rd_cfg_length,
  output logic                      rd_cfg_valid,
  input  logic                      rd_cfg_ready,
  output logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
  output logic [AXI_LEN_WIDTH-1:0]  axi_arlen,
  output logic                      axi_arvalid,
  input  logic                      axi_arready,
  input  logic                      axi_rlast,
  input  logic                      axi_rvalid,
  input  logic                      axi_rready,
  output logic                      done
`ifdef AXIS_READ_SCHED_BURST_CNT_EN
  ,
  output logic [15:0]               burst_cnt
`endif
);
  localparam int BPB = AXI_DATA_WIDTH / 8;
  localparam int BSH = $clog2(BPB);
  localparam int WSH = $clog2(WIDTH_RATIO);
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  typedef enum logic [5:0] {
    IDLE   = 6'b000001,
    CONFIG = 6'b000010,
    CALC   = 6'b000100,
    ADDR   = 6'b001000,
    DRAIN  = 6'b010000,
    DONE   = 6'b100000
  } state_t;
  state_t state, state_n;
  logic [AXI_ADDR_WIDTH-1:0] addr;
  logic [CONFIG_DWIDTH-1:0] beats_rem, burst, burst_c, cap, page_beats;
  logic [CONFIG_DWIDTH:0] len_up;
  logic [12:0] page_bytes;
  logic [OW-1:0] outstanding;
  logic ar_hs, r_done;
  assign ar_hs = axi_arvalid & axi_arready;
  // an rlast with nothing outstanding is spurious and must not underflow the counter
  assign r_done = axi_rvalid & axi_rready & axi_rlast & (outstanding != '0);
  assign len_up = {1'b0, cfg_length} + (CONFIG_DWIDTH+1)'(WIDTH_RATIO - 1);
  assign page_bytes = 13'h1000 - {1'b0, addr[11:0]};
  assign page_beats = CONFIG_DWIDTH'(page_bytes >> BSH);
  assign cap = beats_rem < CONFIG_DWIDTH'(BURST_MAX) ? beats_rem : CONFIG_DWIDTH'(BURST_MAX);
  assign burst_c = page_beats < cap ? page_beats : cap;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (cfg_valid) state_n = cfg_length == '0 ? DONE : CONFIG;
      CONFIG:  if (rd_cfg_ready) state_n = CALC;
      CALC:    if (outstanding < OW'(MAX_OUTSTANDING)) state_n = ADDR;
      ADDR:    if (axi_arready) state_n = beats_rem == burst ? DRAIN : CALC;
      DRAIN:   if (outstanding == '0) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // outputs are registered decodes of the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cfg_ready     <= 1'b1;
      rd_cfg_valid  <= 1'b0;
      rd_cfg_length <= '0;
      axi_arvalid   <= 1'b0;
      axi_araddr    <= '0;
      axi_arlen     <= '0;
      done          <= 1'b0;
      outstanding   <= '0;
      addr          <= '0;
      beats_rem     <= '0;
      burst         <= '0;
    end else begin
      state        <= state_n;
      cfg_ready    <= state_n == IDLE;
      rd_cfg_valid <= state_n == CONFIG;
      axi_arvalid  <= state_n == ADDR;
      done         <= state_n == DONE;
      outstanding  <= outstanding + OW'(ar_hs) - OW'(r_done);
      if (state == IDLE && cfg_valid) begin
        addr          <= AXI_ADDR_WIDTH'(cfg_address) & ~AXI_ADDR_WIDTH'(BPB - 1);
        beats_rem     <= CONFIG_DWIDTH'(len_up >> WSH);
        rd_cfg_length <= cfg_length;
      end
      if (state == CALC) begin
        burst      <= burst_c;
        axi_araddr <= addr;
        axi_arlen  <= AXI_LEN_WIDTH'(burst_c - CONFIG_DWIDTH'(1));
      end
      if (ar_hs) begin
        addr      <= addr + AXI_ADDR_WIDTH'(burst << BSH);
        beats_rem <= beats_rem - burst;
      end
    end
  end
`ifdef AXIS_READ_SCHED_BURST_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && cfg_valid)) burst_cnt <= '0;
    else if (ar_hs && burst_cnt != 16'hFFFF) burst_cnt <= burst_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_axis_read_sched.sv
// tb_axis_read_sched: randomized bench for axis_read_sched against a burst-splitting reference model.
module tb_axis_read_sched;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] cfg_address = '0, cfg_length = '0;
  logic cfg_valid = 1'b0, cfg_ready;
  logic [31:0] rd_cfg_length;
  logic rd_cfg_valid, rd_cfg_ready = 1'b0;
  logic [31:0] axi_araddr;
  logic [7:0] axi_arlen;
  logic axi_arvalid, axi_arready = 1'b0;
  logic axi_rlast = 1'b0, axi_rvalid = 1'b0, axi_rready = 1'b0;
  logic done;
`ifdef AXIS_READ_SCHED_BURST_CNT_EN
  logic [15:0] burst_cnt;
`endif

  axis_read_sched dut (
    .clk(clk), .rst(rst),
    .cfg_address(cfg_address), .cfg_length(cfg_length), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .rd_cfg_length(rd_cfg_length), .rd_cfg_valid(rd_cfg_valid), .rd_cfg_ready(rd_cfg_ready),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .done(done)
`ifdef AXIS_READ_SCHED_BURST_CNT_EN
    , .burst_cnt(burst_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  logic [39:0] exp_q[$], obs_q[$];
  int pending = 0, done_cnt = 0, ar_mode = 0, r_allow = -1;
  bit force_rlast = 1'b0;
  logic prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [7:0] prev_len = '0;

  // AXI slave side: drives arready/R, records AR handshakes, tracks bursts still owed an rlast
  initial forever begin
    @(negedge clk);
    if (prev_wait && !rst) begin
      n_cmp++;
      if ({axi_arvalid, axi_araddr, axi_arlen} !== {1'b1, prev_addr, prev_len}) begin
        n_fail++;
        $display("FAIL ar_stable got v=%b a=%h l=%h want v=1 a=%h l=%h", axi_arvalid, axi_araddr, axi_arlen, prev_addr, prev_len);
      end
    end
    axi_arready = ar_mode == 0 ? 1'b1 : ar_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
    rd_cfg_ready = 1'($urandom_range(0, 1));
    if (force_rlast) begin
      {axi_rvalid, axi_rready, axi_rlast} = 3'b111;
    end else if (pending > 0 && r_allow != 0) begin
      axi_rvalid = $urandom_range(0, 3) != 0;
      axi_rready = $urandom_range(0, 3) != 0;
      axi_rlast  = 1'($urandom_range(0, 1));
      if (axi_rvalid && axi_rready && axi_rlast) begin
        pending--;
        if (r_allow > 0) r_allow--;
      end
    end else begin
      axi_rvalid = 1'b0;
      axi_rready = 1'($urandom_range(0, 1));
      axi_rlast  = 1'($urandom_range(0, 1));
    end
    if (axi_arvalid && axi_arready && !rst) begin
      obs_q.push_back({axi_araddr, axi_arlen});
      pending++;
      n_cmp++;
      if (pending > 4) begin
        n_fail++;
        $display("FAIL outstanding_max got %0d want <=4", pending);
      end
    end
    prev_wait = !rst && axi_arvalid && !axi_arready;
    prev_addr = axi_araddr;
    prev_len  = axi_arlen;
    if (done && !rst) begin
      done_cnt++;
      n_cmp++;
      if (pending != 0) begin
        n_fail++;
        $display("FAIL done_early got pending=%0d want 0", pending);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic start_txn(input logic [31:0] a, input logic [31:0] l);
    logic [31:0] ad;
    longint beats, b, page;
    int n;
    exp_q.delete();
    obs_q.delete();
    done_cnt = 0;
    ad = a & ~32'h7;
    beats = (longint'(l) + 1) / 2;
    while (beats > 0) begin
      page = (4096 - longint'(ad % 4096)) / 8;
      b = beats;
      if (b > 16) b = 16;
      if (b > page) b = page;
      exp_q.push_back({ad, 8'(b - 1)});
      ad += 32'(b * 8);
      beats -= b;
    end
    n = 0;
    while (!cfg_ready && n < 200) begin @(negedge clk); n++; end
    n_cmp++;
    if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL cfg_ready_wait got %b want 1", cfg_ready); end
    cfg_address = a;
    cfg_length  = l;
    cfg_valid   = 1'b1;
    @(negedge clk);
    cfg_valid   = 1'b0;
    cfg_address = $urandom;
    cfg_length  = $urandom;
    n_cmp++;
    if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL cfg_ready_busy got %b want 0", cfg_ready); end
    n_cmp++;
    if (l == 0) begin
      if ({done, rd_cfg_valid} !== 2'b10) begin
        n_fail++;
        $display("FAIL zero_len_done got done=%b rdv=%b want done=1 rdv=0", done, rd_cfg_valid);
      end
    end else if ({rd_cfg_valid, rd_cfg_length} !== {1'b1, l}) begin
      n_fail++;
      $display("FAIL rd_cfg got v=%b len=%0d want v=1 len=%0d", rd_cfg_valid, rd_cfg_length, l);
    end
  endtask

  task automatic finish_txn(input string nm);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 5000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL %s done_pulses got %0d want 1", nm, done_cnt); end
    n_cmp++;
    if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL %s idle_ready got %b want 1", nm, cfg_ready); end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s ar_count got %0d want %0d", nm, obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s ar[%0d] got a=%h l=%0d want a=%h l=%0d", nm, i, obs_q[i][39:8], obs_q[i][7:0], exp_q[i][39:8], exp_q[i][7:0]);
      end
    end
  endtask

  task automatic run_txn(input logic [31:0] a, input logic [31:0] l, input string nm);
    start_txn(a, l);
    finish_txn(nm);
  endtask

  task automatic check_ar(input int idx, input logic [31:0] a, input logic [7:0] l, input string nm);
    n_cmp++;
    if (idx >= obs_q.size() || obs_q[idx] !== {a, l}) begin
      n_fail++;
      $display("FAIL %s ar%0d got %h want a=%h l=%0d", nm, idx, idx < obs_q.size() ? obs_q[idx] : 40'h0, a, l);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({cfg_ready, rd_cfg_valid, axi_arvalid, axi_araddr, axi_arlen, done} !== {3'b100, 32'h0, 8'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset got rdy=%b rdv=%b arv=%b a=%h l=%h done=%b want 1 0 0 0 0 0",
               cfg_ready, rd_cfg_valid, axi_arvalid, axi_araddr, axi_arlen, done);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    run_txn(32'h1000, 64, "basic");
    check_ar(0, 32'h1000, 8'd15, "basic");
    check_ar(1, 32'h1080, 8'd15, "basic");
`ifdef AXIS_READ_SCHED_BURST_CNT_EN
    n_cmp++;
    if (burst_cnt !== 16'd2) begin n_fail++; $display("FAIL burst_cnt got %0d want 2", burst_cnt); end
`endif
  endtask

  task automatic test_page_cross;
    run_txn(32'h0FF0, 20, "page");
    check_ar(0, 32'h0FF0, 8'd1, "page");
    check_ar(1, 32'h1000, 8'd7, "page");
  endtask

  task automatic test_unaligned;
    run_txn(32'h2004, 3, "unaligned");
    check_ar(0, 32'h2000, 8'd1, "unaligned");
  endtask

  task automatic test_wrap;
    run_txn(32'hFFFF_FFC0, 40, "wrap");
    check_ar(0, 32'hFFFF_FFC0, 8'd7, "wrap");
    check_ar(1, 32'h0, 8'd11, "wrap");
  endtask

  task automatic test_zero_len;
    run_txn(32'h40, 0, "zero");
  endtask

  task automatic test_outstanding;
    int n;
    r_allow = 0;
    start_txn(32'h1000, 160);
    n = 0;
    while (obs_q.size() < 4 && n < 300) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (obs_q.size() != 4 || axi_arvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall got ars=%0d arv=%b want 4 0", obs_q.size(), axi_arvalid);
    end
    r_allow = 1;
    n = 0;
    while (obs_q.size() < 5 && n < 300) begin @(negedge clk); n++; end
    check_ar(4, 32'h1200, 8'd15, "stall");
    r_allow = -1;
    finish_txn("stall");
  endtask

  task automatic test_reset_mid;
    int n;
    r_allow = 0;
    start_txn(32'h3000, 160);
    n = 0;
    while (obs_q.size() < 4 && n < 300) begin @(negedge clk); n++; end
    ar_mode = 2;
    r_allow = 1;
    n = 0;
    while (!axi_arvalid && n < 300) begin @(negedge clk); n++; end
    r_allow = 0;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({axi_arvalid, cfg_ready, rd_cfg_valid, dut.outstanding} !== {3'b010, 3'd0}) begin
      n_fail++;
      $display("FAIL rst_mid got arv=%b rdy=%b rdv=%b out=%0d want 0 1 0 0", axi_arvalid, cfg_ready, rd_cfg_valid, dut.outstanding);
    end
    pending = 0;
    @(negedge clk);
    rst = 1'b0;
    ar_mode = 0;
    r_allow = -1;
    @(negedge clk);
    run_txn(32'h5000, 30, "after_rst");
  endtask

  task automatic test_spurious;
    force_rlast = 1'b1;
    repeat (3) @(negedge clk);
    force_rlast = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (dut.outstanding !== 3'd0) begin n_fail++; $display("FAIL spurious got out=%0d want 0", dut.outstanding); end
    run_txn(32'h6000, 16, "spurious");
  endtask

  task automatic test_random;
    logic [31:0] a;
    ar_mode = 1;
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[11:0] = 12'hF00 | 12'($urandom_range(0, 255));
      run_txn(a, 32'($urandom_range(0, 300)), "random");
    end
    ar_mode = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_page_cross();
    test_unaligned();
    test_wrap();
    test_zero_len();
    test_outstanding();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_read_sched.md
Name: axis_read_sched

Overview:
Sequences one stream read transaction end to end. Accepts a start address and a length in stream words, then programs the downstream read-data block's config port. It splits the transfer into AXI read bursts that never cross a 4 KB boundary and never exceed BURST_MAX beats, and drives the AXI AR channel. It counts bursts in flight by monitoring R-channel last beats, and reports completion once every burst has returned.

Parameters:
CONFIG_DWIDTH, 32, width of cfg_address, cfg_length and rd_cfg_length
AXI_ADDR_WIDTH, 32, AXI address width
AXI_LEN_WIDTH, 8, width of axi_arlen
AXI_DATA_WIDTH, 64, AXI data width in bits; bytes per beat BPB = AXI_DATA_WIDTH/8, power of two
WIDTH_RATIO, 2, stream words per AXI beat, power of two
BURST_MAX, 16, maximum beats per burst, ≤ 2^AXI_LEN_WIDTH
MAX_OUTSTANDING, 4, maximum AR bursts issued without a returned rlast

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cfg_address  in  CONFIG_DWIDTH  start byte address; low log2(BPB) bits are ignored and forced to 0
cfg_length  in  CONFIG_DWIDTH  transfer length in stream words
cfg_valid  in  1  config request
cfg_ready  out  1  high only in IDLE
rd_cfg_length  out  CONFIG_DWIDTH  length sent to the read-data block, equal to the latched cfg_length
rd_cfg_valid  out  1  config valid to the read-data block
rd_cfg_ready  in  1  read-data block ready
axi_araddr  out  AXI_ADDR_WIDTH  burst address
axi_arlen  out  AXI_LEN_WIDTH  burst beats minus 1
axi_arvalid  out  1  AR valid
axi_arready  in  1  AR ready
axi_rlast  in  1  R last beat (monitored only)
axi_rvalid  in  1  R valid (monitored only)
axi_rready  in  1  R ready as driven by the read-data block (monitored only)
done  out  1  one-cycle pulse when the transaction completes

Behaviour:
- Reset values: cfg_ready=1 (IDLE), rd_cfg_valid=0, axi_arvalid=0, axi_araddr=0, axi_arlen=0, done=0, outstanding=0. All outputs are registered.
- States are one-hot: IDLE, CONFIG, CALC, ADDR, DRAIN, DONE.
- IDLE:
  - On cfg_valid, latch the address and length.
  - Compute beats_rem = (cfg_length + WIDTH_RATIO-1) >> log2(WIDTH_RATIO).
  - cfg_length==0 → DONE. Otherwise → CONFIG.
- CONFIG: rd_cfg_valid=1 until rd_cfg_ready, then → CALC. rd_cfg_valid is asserted on the cycle after cfg acceptance.
- CALC (1 cycle):
  - burst = min(beats_rem, BURST_MAX, (4096 - addr[11:0]) / BPB).
  - Load axi_araddr=addr and axi_arlen=burst-1.
  - If outstanding < MAX_OUTSTANDING → ADDR with axi_arvalid=1. Otherwise stay in CALC.
- ADDR:
  - axi_arvalid, axi_araddr and axi_arlen are held stable until axi_arready.
  - On the handshake: arvalid=0, addr += burst*BPB, beats_rem -= burst.
  - Then beats_rem==0 → DRAIN, else → CALC. This costs at least one bubble cycle per burst.
- DRAIN: wait until outstanding==0 → DONE.
- DONE: done=1 for one cycle → IDLE.
- Outstanding counter:
  - +1 on an AR handshake; -1 on axi_rvalid & axi_rready & axi_rlast.
  - Both in the same cycle → unchanged.
  - Width is clog2(MAX_OUTSTANDING+1). It never exceeds MAX_OUTSTANDING and never underflows; a spurious rlast at 0 is ignored.
- Address arithmetic wraps modulo 2^AXI_ADDR_WIDTH. A burst never spans a 4 KB page.
- cfg_valid outside IDLE is ignored (cfg_ready=0).
- Reset mid-operation:
  - The next cycle is IDLE; arvalid and rd_cfg_valid drop and outstanding clears.
  - In-flight R beats are not tracked; the system resets the read-data block alongside.

Optional Feature:
AXIS_READ_SCHED_BURST_CNT_EN:
- Defined: adds output burst_cnt [15:0]. It clears on cfg acceptance, increments on each AR handshake, saturates at 0xFFFF, and holds after done.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- addr 0x1000, len 64 (32 beats), arready=1, R returns promptly → rd_cfg_length=64; ARs (0x1000, arlen 15), (0x1080, arlen 15); one done pulse after the 2nd rlast.
- addr 0x0FF0, len 20 (10 beats) → ARs (0x0FF0, arlen 1), (0x1000, arlen 7); no 4 KB crossing.
- addr 0x2004, len 3 → address forced to 0x2000; 2 beats; single AR (0x2000, arlen 1).
- len 160 (80 beats), arready=1, rvalid=0 → exactly 4 AR handshakes then stall in CALC. One rlast → 5th AR (0x1200, arlen 15) issued; done after 5 rlasts.
- len 0 → cfg_ready low 1 cycle, done pulse 1 cycle after acceptance, no rd_cfg_valid, no arvalid.
- rst asserted while arvalid=1 with arready=0 → next cycle arvalid=0, cfg_ready=1, outstanding=0. A new request then runs normally.
